// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state encoding,
// key-code lookup and column rotation.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN             = 2'd0,
        DEBOUNCE_PRESS   = 2'd1,
        HELD             = 2'd2,
        DEBOUNCE_RELEASE = 2'd3
    } scan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [3:0] col_rotate(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    // Rows are one-hot with bit 3 = top row; columns are one-hot with bit 0 = left column.
    function automatic logic [3:0] key_map(input logic [3:0] row_onehot, input logic [3:0] col_onehot);
        logic [3:0] code;
        code = 4'h0;
        case ({row_onehot, col_onehot})
            8'b1000_0001: code = 4'h1;
            8'b1000_0010: code = 4'h2;
            8'b1000_0100: code = 4'h3;
            8'b1000_1000: code = 4'hA;
            8'b0100_0001: code = 4'h4;
            8'b0100_0010: code = 4'h5;
            8'b0100_0100: code = 4'h6;
            8'b0100_1000: code = 4'hB;
            8'b0010_0001: code = 4'h7;
            8'b0010_0010: code = 4'h8;
            8'b0010_0100: code = 4'h9;
            8'b0010_1000: code = 4'hC;
            8'b0001_0001: code = 4'hE;
            8'b0001_0010: code = 4'h0;
            8'b0001_0100: code = 4'hF;
            8'b0001_1000: code = 4'hD;
            default:      code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the four asynchronous keypad row lines.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw,
    output logic [3:0] synced
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= 4'b0000;
            synced <= 4'b0000;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix-keypad scanner with press/release debounce and a one-cycle key strobe.
// Optional auto-repeat while a key is held is built when KEYPAD_AUTOREPEAT_EN is defined.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_sense,
    output logic [3:0] col_drive,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(max3(SCAN_CYCLES, DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       latched_row;
    logic [3:0]       rs;
    logic             row_active;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rep_cnt;
`endif

    keypad_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .raw    (row_sense),
        .synced (rs)
    );

    assign row_active = |(rs & latched_row);

    // One shared counter times both the column dwell and the debounce windows;
    // the column is frozen from detection until the release is confirmed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SCAN;
            cnt         <= '0;
            latched_row <= 4'b0000;
            col_drive   <= 4'b0001;
            key_value   <= 4'h0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if ($onehot(rs)) begin
                            latched_row <= rs;
                            state       <= DEBOUNCE_PRESS;
                        end else begin
                            col_drive <= col_rotate(col_drive);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (rs == latched_row) begin
                        if (cnt == DEB_LAST) begin
                            state     <= HELD;
                            cnt       <= '0;
                            key_value <= key_map(latched_row, col_drive);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state     <= SCAN;
                        cnt       <= '0;
                        col_drive <= col_rotate(col_drive);
                    end
                end
                HELD: begin
                    if (!row_active) begin
                        cnt   <= '0;
                        state <= DEBOUNCE_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        rep_cnt   <= '0;
                        key_valid <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                DEBOUNCE_RELEASE: begin
                    if (row_active) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= SCAN;
                        cnt       <= '0;
                        col_drive <= col_rotate(col_drive);
                        key_held  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
